// File: rtl/arbiter_2way_if.sv
// Request/grant bundle between two bus masters and the 2-way arbiter.
// Latency: none (wires only).
// Backpressure: none; a requester keeps req high until it has finished with its grant.
//
// Signals:
//   req_0, req_1 : level-sensitive requests, driven by the masters
//   gnt_0, gnt_1 : one-hot registered grants, driven by the arbiter
// Modports:
//   master : requester side (drives req, observes gnt)
//   slave  : arbiter side   (observes req, drives gnt)
interface arbiter_2way_if;
    logic req_0;
    logic req_1;
    logic gnt_0;
    logic gnt_1;

    modport master (
        output req_0,
        output req_1,
        input  gnt_0,
        input  gnt_1
    );

    modport slave (
        input  req_0,
        input  req_1,
        output gnt_0,
        output gnt_1
    );
endinterface

// File: rtl/arbiter_2way.sv
// Two-requester arbiter giving exclusive, one-hot access to one shared slave port.
// Latency: a request sampled high at edge N gives its grant after edge N (one cycle); release is also one cycle.
// Backpressure: a grant is held while its request stays high, bounded by HOLD_LIMIT when the other side waits.
//
// Ports:
//   clk    : rising-edge clock
//   nreset : asynchronous reset, ACTIVE-HIGH despite its name (1 = reset)
//   bus    : arbiter_2way_if.slave -- req_0/req_1 in, gnt_0/gnt_1 out
// Parameters:
//   HOLD_LIMIT : max consecutive grant cycles while the other side requests; 0 = unlimited (0..255)
// Build option:
//   ARBITER_RR_EN : when defined, IDLE ties go round-robin (to the requester that was not
//                   granted last); when undefined, ties always go to requester 0.
module arbiter_2way #(
    parameter int unsigned HOLD_LIMIT = 0
) (
    input  logic          clk,
    input  logic          nreset,
    arbiter_2way_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Count value at which the owner has used up its allowance; only meaningful when
    // HOLD_LIMIT is non-zero.
    localparam logic [7:0] HOLD_LAST = (HOLD_LIMIT == 0) ? 8'd0 : 8'(HOLD_LIMIT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] hold_q;
    logic [7:0] hold_d;
    logic       last_q;   // most recently granted requester (0 or 1)
    logic       last_d;

    logic       req_0;
    logic       req_1;
    logic       hold_expired;
    logic       tie_to_1;

    assign req_0 = bus.req_0;
    assign req_1 = bus.req_1;

    // Grants are a pure decode of the state register, so they are glitch-free,
    // registered and one-hot by construction.
    assign bus.gnt_0 = (state_q == GNT0);
    assign bus.gnt_1 = (state_q == GNT1);

    // The counter never climbs past HOLD_LAST while a limit is set (the owner is
    // switched out there), but compare with >= so a corrupted count still yields.
    assign hold_expired = (HOLD_LIMIT != 0) && (hold_q >= HOLD_LAST);

`ifdef ARBITER_RR_EN
    // Give the tie to whichever requester was not served most recently.
    assign tie_to_1 = ~last_q;
`else
    // Fixed priority: requester 0 always wins a tie; last_q is tracked but unused here.
    assign tie_to_1 = 1'b0;
`endif

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            last_q  <= 1'b1;   // so requester 0 wins the first tie in either build
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
                    state_d = tie_to_1 ? GNT1 : GNT0;
                end else if (req_0) begin
                    state_d = GNT0;
                end else if (req_1) begin
                    state_d = GNT1;
                end
            end

            GNT0: begin
                if (req_0 && !(hold_expired && req_1)) begin
                    // Owner keeps the bus; only time spent while the other side
                    // waits counts against its allowance. Saturate, never wrap.
                    if (req_1 && (hold_q != 8'hFF)) begin
                        hold_d = hold_q + 8'd1;
                    end
                end else if (req_1) begin
                    // Either a voluntary release or a forced yield; both hand over
                    // directly with no IDLE bubble.
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end

            GNT1: begin
                if (req_1 && !(hold_expired && req_0)) begin
                    if (req_0 && (hold_q != 8'hFF)) begin
                        hold_d = hold_q + 8'd1;
                    end
                end else if (req_0) begin
                    state_d = GNT0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Every ownership change starts a fresh allowance.
        if (state_d != state_q) begin
            hold_d = 8'd0;
        end

        // Track who was granted last, including forced hold-limit switches.
        if (state_d == GNT0) begin
            last_d = 1'b0;
        end else if (state_d == GNT1) begin
            last_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_arbiter_2way.sv
// Self-checking bench for arbiter_2way: two instances (HOLD_LIMIT 0 and 4) driven by
// directed sequences and random requests, compared against an owner/allowance model.
// Summary line reports total checks and errors.
module tb_arbiter_2way;

`ifdef ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic nreset;

    arbiter_2way_if bus_a ();
    arbiter_2way_if bus_h ();

    arbiter_2way #(.HOLD_LIMIT(0)) dut_a (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus_a)
    );

    arbiter_2way #(.HOLD_LIMIT(4)) dut_h (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 = nobody), how many cycles of the
    // owner's allowance have been used while the other side waited, who was last served.
    int m_owner  [2];
    int m_cnt    [2];
    int m_last   [2];
    bit m_switch [2];
    int lim      [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i]  = -1;
            m_cnt[i]    = 0;
            m_last[i]   = 1;
            m_switch[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input int i, input bit r0, input bit r1);
        int nxt;
        bit mine;
        bit theirs;
        bit expired;
        nxt         = -1;
        mine        = 1'b0;
        theirs      = 1'b0;
        m_switch[i] = 1'b0;
        if (m_owner[i] < 0) begin
            if (r0 && r1)  nxt = (RR && m_last[i] == 0) ? 1 : 0;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
        end else begin
            mine    = (m_owner[i] == 0) ? r0 : r1;
            theirs  = (m_owner[i] == 0) ? r1 : r0;
            expired = (lim[i] != 0) && (m_cnt[i] >= lim[i] - 1);
            if (mine && !(expired && theirs)) begin
                nxt = m_owner[i];
            end else if (theirs) begin
                nxt         = 1 - m_owner[i];
                m_switch[i] = mine;
            end
        end
        if (nxt != m_owner[i])                        m_cnt[i] = 0;
        else if (nxt >= 0 && theirs && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        if (nxt >= 0) m_last[i] = nxt;
        m_owner[i] = nxt;
    endfunction

    // One clock: present requests (called at negedge), advance the model at the edge,
    // then compare 1 time unit later. Ends on the following negedge.
    task automatic step(input bit a0, input bit a1, input bit h0, input bit h1, input string tag);
        bus_a.req_0 = a0;
        bus_a.req_1 = a1;
        bus_h.req_0 = h0;
        bus_h.req_1 = h1;
        @(posedge clk);
        model_edge(0, a0, a1);
        model_edge(1, h0, h1);
        #1;
        check({tag, ".a.gnt_0"}, int'(bus_a.gnt_0), int'(m_owner[0] == 0));
        check({tag, ".a.gnt_1"}, int'(bus_a.gnt_1), int'(m_owner[0] == 1));
        check({tag, ".h.gnt_0"}, int'(bus_h.gnt_0), int'(m_owner[1] == 0));
        check({tag, ".h.gnt_1"}, int'(bus_h.gnt_1), int'(m_owner[1] == 1));
        check({tag, ".a.mutex"}, int'(bus_a.gnt_0 & bus_a.gnt_1), 0);
        check({tag, ".h.mutex"}, int'(bus_h.gnt_0 & bus_h.gnt_1), 0);
        check({tag, ".a.cause"}, int'((bus_a.gnt_0 && !a0 || bus_a.gnt_1 && !a1) && !m_switch[0]), 0);
        check({tag, ".h.cause"}, int'((bus_h.gnt_0 && !h0 || bus_h.gnt_1 && !h1) && !m_switch[1]), 0);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        bus_a.req_0 = 1'b0;
        bus_a.req_1 = 1'b0;
        bus_h.req_0 = 1'b0;
        bus_h.req_1 = 1'b0;
        #2;
        nreset = 1'b1;
        model_reset();
        #1;
        check({tag, ".rst.a"}, int'({bus_a.gnt_0, bus_a.gnt_1}), 0);
        check({tag, ".rst.h"}, int'({bus_h.gnt_0, bus_h.gnt_1}), 0);
        @(negedge clk);
        nreset = 1'b0;
    endtask

    initial begin
        lim[0] = 0;
        lim[1] = 4;
        model_reset();
        nreset      = 1'b1;
        bus_a.req_0 = 1'b0;
        bus_a.req_1 = 1'b0;
        bus_h.req_0 = 1'b1;   // requests during reset must be ignored
        bus_h.req_1 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.a", int'({bus_a.gnt_0, bus_a.gnt_1}), 0);
        check("reset.h", int'({bus_h.gnt_0, bus_h.gnt_1}), 0);
        bus_h.req_0 = 1'b0;
        bus_h.req_1 = 1'b0;
        nreset      = 1'b0;

        // Released with no requests: nothing granted.
        step(0, 0, 0, 0, "idle0");
        step(0, 0, 0, 0, "idle1");

        // Single one-cycle requests.
        step(1, 0, 1, 0, "single0.on");
        check("single0.gnt_0", int'(bus_a.gnt_0), 1);
        step(0, 0, 0, 0, "single0.off");
        check("single0.gnt_0_off", int'(bus_a.gnt_0), 0);
        step(0, 1, 0, 1, "single1.on");
        check("single1.gnt_1", int'(bus_a.gnt_1), 1);
        step(0, 0, 0, 0, "single1.off");
        check("single1.gnt_1_off", int'(bus_a.gnt_1), 0);

        // Tie after reset, then direct handover.
        do_reset("tie");
        step(1, 1, 1, 1, "tie.both");
        check("tie.gnt", int'({bus_a.gnt_0, bus_a.gnt_1}), 2);
        step(0, 1, 0, 1, "tie.handover");
        check("handover.gnt", int'({bus_a.gnt_0, bus_a.gnt_1}), 1);
        step(0, 0, 0, 0, "tie.idle");

        // Asynchronous reset in the middle of a GNT0 tenure.
        step(1, 0, 1, 0, "async.grant");
        step(1, 0, 1, 0, "async.hold");
        #2;
        nreset = 1'b1;
        model_reset();
        #1;
        check("async.a", int'({bus_a.gnt_0, bus_a.gnt_1}), 0);
        check("async.h", int'({bus_h.gnt_0, bus_h.gnt_1}), 0);
        @(negedge clk);
        @(negedge clk);
        check("async.held.a", int'({bus_a.gnt_0, bus_a.gnt_1}), 0);
        nreset = 1'b0;
        step(0, 0, 0, 0, "async.release");

        // Ties separated by IDLE: round-robin alternates, fixed priority stays on 0.
        do_reset("rr");
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 1, 1, "rr.tie");
            check("rr.winner", int'(bus_a.gnt_1), RR ? (k % 2) : 0);
            step(0, 0, 0, 0, "rr.idle");
        end

        // Both held continuously: limit 4 alternates every 4 cycles, unlimited never yields.
        do_reset("hold");
        for (int k = 0; k < 16; k++) begin
            step(1, 1, 1, 1, "hold.both");
            check("hold.h.gnt_1", int'(bus_h.gnt_1), (k / 4) % 2);
            check("hold.a.gnt_0", int'(bus_a.gnt_0), 1);
        end
        step(0, 0, 0, 0, "hold.idle");

        // Random traffic with sticky-ish requests and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            bit a0, a1, h0, h1;
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand");
            end
            a0 = ($urandom_range(0, 3) != 0) ? bus_a.req_0 : 1'($urandom_range(0, 1));
            a1 = ($urandom_range(0, 3) != 0) ? bus_a.req_1 : 1'($urandom_range(0, 1));
            h0 = ($urandom_range(0, 3) != 0) ? bus_h.req_0 : 1'($urandom_range(0, 1));
            h1 = ($urandom_range(0, 3) != 0) ? bus_h.req_1 : 1'($urandom_range(0, 1));
            step(a0, a1, h0, h1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
